memory_control: RTL and testbench

MEMORY_CONTROL -- requirements
Module: memory_control

---
 rtl/cpu_types_pkg.sv | 20 ++
 rtl/memctl_arb.sv | 22 ++
 rtl/memory_control.sv | 139 +++++++++++++
 tb/tb_memory_control.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared types for the memory controller: RAM status codes and arbiter FSM states.
package cpu_types_pkg;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DGRANT = 2'd1,
        IGRANT = 2'd2,
        DONE   = 2'd3
    } memctl_state_t;

    localparam logic [31:0] BAD_LOAD = 32'hBAD1BAD1;

endpackage

// File: rtl/memctl_arb.sv
// Next-grant selection from IDLE: dcache priority, except icache goes first
// when the previous completed grant went to the dcache and both are asking.
module memctl_arb
    import cpu_types_pkg::*;
(
    input  logic          ireq,
    input  logic          dreq,
    input  logic          last_dcache,
    output memctl_state_t next_grant
);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        next_grant = IDLE;
        if (dreq && !(ireq && last_dcache)) begin
            next_grant = DGRANT;
        end else if (ireq) begin
            next_grant = IGRANT;
        end
    end

endmodule

// File: rtl/memory_control.sv
// Arbitrates icache and dcache word accesses onto a single RAM port, with
// access timeout, sticky error reporting and one bubble cycle between transfers.
module memory_control
    import cpu_types_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,
    output logic        merr
);

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    memctl_state_t state, next_state, arb_grant;
    ramstate_t     rs;
    logic [7:0]    count;
    logic          last_dcache;
    logic          finish;
    logic          abort;
    logic          dreq;

    assign rs   = ramstate_t'(ramstate);
    assign dreq = dREN | dWEN;

    memctl_arb u_arb (
        .ireq        (iREN),
        .dreq        (dreq),
        .last_dcache (last_dcache),
        .next_grant  (arb_grant)
    );

    always_comb begin
        next_state = state;
        iwait      = 1'b1;
        dwait      = 1'b1;
        iload      = '0;
        dload      = '0;
        ramREN     = 1'b0;
        ramWEN     = 1'b0;
        ramaddr    = '0;
        ramstore   = '0;
        finish     = 1'b0;
        abort      = 1'b0;

        unique case (state)
            IDLE: next_state = arb_grant;

            DGRANT: begin
                if (!dreq) begin
                    next_state = IDLE;
                end else begin
                    ramaddr  = daddr;
                    ramstore = dstore;
                    ramWEN   = dWEN;
                    ramREN   = dREN & ~dWEN;
                    if (rs == ACCESS) begin
                        dwait      = 1'b0;
                        dload      = ramload;
                        finish     = 1'b1;
                        next_state = DONE;
                    end else if (rs == ERROR || count >= TIMEOUT_CNT) begin
                        dwait      = 1'b0;
                        dload      = BAD_LOAD;
                        finish     = 1'b1;
                        abort      = 1'b1;
                        next_state = DONE;
                    end
                end
            end

            IGRANT: begin
                if (!iREN) begin
                    next_state = IDLE;
                end else begin
                    ramaddr = iaddr;
                    ramREN  = 1'b1;
                    if (rs == ACCESS) begin
                        iwait      = 1'b0;
                        iload      = ramload;
                        finish     = 1'b1;
                        next_state = DONE;
                    end else if (rs == ERROR || count >= TIMEOUT_CNT) begin
                        iwait      = 1'b0;
                        iload      = BAD_LOAD;
                        finish     = 1'b1;
                        abort      = 1'b1;
                        next_state = DONE;
                    end
                end
            end

            DONE: next_state = IDLE;

            default: next_state = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state       <= IDLE;
            count       <= '0;
            last_dcache <= 1'b0;
            merr        <= 1'b0;
        end else begin
            state <= next_state;
            // The counter only runs while the same grant keeps waiting.
            if ((state == DGRANT || state == IGRANT) && next_state == state) begin
                count <= (count == 8'hFF) ? count : count + 8'd1;
            end else begin
                count <= '0;
            end
            if (finish) begin
                last_dcache <= (state == DGRANT);
            end
            if (abort) begin
                merr <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_memory_control.sv
// Self-checking bench for memory_control: directed scenarios plus randomized
// transactions checked against a transaction-level arbitration/latency model.
module tb_memory_control;
    import cpu_types_pkg::*;

    localparam int TO = 4;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        iREN, dREN, dWEN;
    logic [31:0] iaddr, daddr, dstore, ramload;
    logic [1:0]  ramstate;
    logic        iwait, dwait, ramREN, ramWEN, merr;
    logic [31:0] iload, dload, ramaddr, ramstore;

    int checks   = 0;
    int failures = 0;
    bit last_d   = 1'b0;
    bit exp_merr = 1'b0;

    memory_control #(.TIMEOUT(TO)) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iwait    (iwait),
        .iload    (iload),
        .dREN     (dREN),
        .dWEN     (dWEN),
        .daddr    (daddr),
        .dstore   (dstore),
        .dwait    (dwait),
        .dload    (dload),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ramload  (ramload),
        .ramstate (ramstate),
        .merr     (merr)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Runs one granted transfer from its first grant cycle through the DONE bubble.
    // lat = BUSY cycles before ramstate reports ACCESS (or ERROR when err is set).
    task automatic serve(input bit own_d, input int lat, input bit err, input logic [31:0] data);
        int          pk;
        bit          ok;
        logic [31:0] e_addr, e_store, e_load, o_load, n_load;
        logic        e_ren, e_wen, o_wait, n_wait, e_wait;
        pk = (lat < TO) ? lat + 1 : TO + 1;
        ok = (lat < TO) && !err;
        for (int k = 1; k <= pk; k++) begin
            if (k == lat + 1) ramstate = err ? ERROR : ACCESS;
            else              ramstate = BUSY;
            ramload = data;
            @(negedge CLK);
            if (own_d) begin
                e_addr = daddr; e_store = dstore; e_wen = dWEN; e_ren = dREN & ~dWEN;
                o_wait = dwait; o_load = dload; n_wait = iwait; n_load = iload;
            end else begin
                e_addr = iaddr; e_store = '0; e_wen = 1'b0; e_ren = 1'b1;
                o_wait = iwait; o_load = iload; n_wait = dwait; n_load = dload;
            end
            checks++;
            if ({ramaddr, ramstore, ramREN, ramWEN} !== {e_addr, e_store, e_ren, e_wen}) begin
                failures++;
                $display("FAIL grant_bus cyc%0d: got addr=%h store=%h ren=%b wen=%b expected addr=%h store=%h ren=%b wen=%b",
                         k, ramaddr, ramstore, ramREN, ramWEN, e_addr, e_store, e_ren, e_wen);
            end
            e_wait = (k != pk);
            e_load = (k != pk) ? 32'h0 : (ok ? data : 32'hBAD1BAD1);
            checks++;
            if ({o_wait, o_load, n_wait, n_load} !== {e_wait, e_load, 1'b1, 32'h0}) begin
                failures++;
                $display("FAIL owner_resp cyc%0d (owner_d=%0b): got wait=%b load=%h other_wait=%b other_load=%h expected wait=%b load=%h other 1/0",
                         k, own_d, o_wait, o_load, n_wait, n_load, e_wait, e_load);
            end
            step();
        end
        if (!ok) exp_merr = 1'b1;
        last_d   = own_d;
        ramstate = FREE;
        @(negedge CLK);
        checks++;
        if ({iwait, dwait, ramREN, ramWEN, iload, dload, merr} !== {1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, exp_merr}) begin
            failures++;
            $display("FAIL done_bubble: got iw=%b dw=%b ren=%b wen=%b il=%h dl=%h merr=%b expected 1 1 0 0 0 0 merr=%b",
                     iwait, dwait, ramREN, ramWEN, iload, dload, merr, exp_merr);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        checks++;
        if ({iwait, dwait, ramREN, ramWEN, ramaddr, ramstore, iload, dload, merr} !==
            {1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0}) begin
            failures++;
            $display("FAIL %s: got iw=%b dw=%b ren=%b wen=%b addr=%h store=%h il=%h dl=%h merr=%b expected reset values",
                     name, iwait, dwait, ramREN, ramWEN, ramaddr, ramstore, iload, dload, merr);
        end
    endtask

    task automatic test_reset();
        nRST = 1'b0; iREN = 1'b1; dREN = 1'b1; dWEN = 1'b0;
        iaddr = 32'h1234; daddr = 32'h5678; dstore = 32'h9ABC;
        ramload = 32'hFFFF_FFFF; ramstate = ACCESS;
        #12;
        check_reset_outputs("reset_values");
        iREN = 1'b0; dREN = 1'b0; ramstate = FREE;
        @(negedge CLK);
        nRST = 1'b1;
        step();
        check_reset_outputs("idle_after_reset");
    endtask

    task automatic test_dread();
        dREN = 1'b1; daddr = 32'h40;
        step();
        serve(1'b1, 2, 1'b0, 32'hDEADBEEF);
        dREN = 1'b0;
        step();
    endtask

    task automatic test_fairness();
        iREN = 1'b1; iaddr = 32'h1000;
        step();
        serve(1'b0, 0, 1'b0, 32'h1111_0000);
        iREN = 1'b0;
        step();
        iREN = 1'b1; iaddr = 32'h2000; dWEN = 1'b1; daddr = 32'h80; dstore = 32'hCAFEF00D;
        step();
        serve(1'b1, 1, 1'b0, 32'h0);
        dWEN = 1'b0;
        step();
        step();
        serve(1'b0, 1, 1'b0, 32'h2222_2222);
        iREN = 1'b0;
        step();
    endtask

    task automatic test_back_to_back();
        iREN = 1'b1; iaddr = 32'h3000; dREN = 1'b1; daddr = 32'h40;
        step();
        serve(1'b1, 0, 1'b0, 32'hA0A0_0040);
        daddr = 32'h44;
        step();
        step();
        serve(1'b0, 2, 1'b0, 32'hB0B0_3000);
        iREN = 1'b0;
        step();
        step();
        serve(1'b1, 1, 1'b0, 32'hA0A0_0044);
        dREN = 1'b0;
        step();
    endtask

    task automatic test_drop();
        dREN = 1'b1; daddr = 32'h100; ramstate = BUSY;
        step();
        @(negedge CLK);
        checks++;
        if (ramREN !== 1'b1 || ramaddr !== 32'h100) begin
            failures++;
            $display("FAIL drop_grant: got ren=%b addr=%h expected ren=1 addr=00000100", ramREN, ramaddr);
        end
        step();
        dREN = 1'b0;
        #1;
        checks++;
        if ({ramREN, ramWEN, ramaddr, dwait, iwait, dload} !== {1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0}) begin
            failures++;
            $display("FAIL drop_release: got ren=%b wen=%b addr=%h dw=%b iw=%b dl=%h expected 0 0 0 1 1 0",
                     ramREN, ramWEN, ramaddr, dwait, iwait, dload);
        end
        step();
        ramstate = FREE;
        @(negedge CLK);
        checks++;
        if ({dwait, iwait, ramREN} !== {1'b1, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL drop_idle: got dw=%b iw=%b ren=%b expected 1 1 0", dwait, iwait, ramREN);
        end
    endtask

    task automatic test_timeout();
        dREN = 1'b1; daddr = 32'h200;
        step();
        serve(1'b1, 100, 1'b0, 32'h5555_5555);
        dREN = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            @(negedge CLK);
            checks++;
            if (merr !== 1'b1) begin
                failures++;
                $display("FAIL merr_sticky: got %b expected 1", merr);
            end
        end
        step();
    endtask

    task automatic test_error();
        dREN = 1'b1; dWEN = 1'b1; daddr = 32'h300; dstore = 32'h0BAD_F00D;
        step();
        serve(1'b1, 1, 1'b1, 32'h7777_7777);
        dREN = 1'b0; dWEN = 1'b0;
        step();
    endtask

    task automatic test_random();
        bit          ir, dr, dw, dd, er, exp_d;
        int          r, lat;
        for (int n = 0; n < 40; n++) begin
            ir = 1'($urandom % 2);
            dr = 1'($urandom % 2);
            if (!ir && !dr) ir = 1'b1;
            dw = dr ? 1'($urandom % 2) : 1'b0;
            dd = dr && (!dw || 1'($urandom % 2));
            r   = int'($urandom % 5);
            lat = (r < 4) ? r : 6;
            er  = ($urandom % 8) == 0;
            exp_d = dr && !(ir && last_d);
            iREN = ir; dREN = dd; dWEN = dw;
            iaddr = $urandom; daddr = $urandom; dstore = $urandom;
            step();
            serve(exp_d, lat, er, $urandom);
            iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
            step();
        end
    endtask

    task automatic test_reset_mid();
        dREN = 1'b1; daddr = 32'h400; ramstate = BUSY;
        step();
        @(negedge CLK);
        checks++;
        if (ramREN !== 1'b1) begin
            failures++;
            $display("FAIL mid_reset_pre: got ren=%b expected 1", ramREN);
        end
        step();
        nRST = 1'b0;
        #1;
        check_reset_outputs("mid_reset_same_cycle");
        exp_merr = 1'b0;
        last_d   = 1'b0;
        @(negedge CLK);
        nRST = 1'b1;
        #1;
        checks++;
        if ({dwait, iwait, ramREN, dload} !== {1'b1, 1'b1, 1'b0, 32'h0}) begin
            failures++;
            $display("FAIL mid_reset_release: got dw=%b iw=%b ren=%b dl=%h expected 1 1 0 0",
                     dwait, iwait, ramREN, dload);
        end
        dREN = 1'b0; ramstate = FREE;
        step();
    endtask

    initial begin
        test_reset();
        test_dread();
        test_fairness();
        test_back_to_back();
        test_drop();
        test_timeout();
        test_error();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
